// File: rtl/crc16_check_bluetooth.sv
// Bluetooth CRC-16 receive checker.
// Seeds a CRC-CCITT LFSR (x^16+x^12+x^5+1) from the bit-reversed UAP/DCI,
// shifts payload_len payload bits followed by the 16 received CRC bits
// through it, and flags crc_ok when the register ends at zero.
// Ports:
//   clk, reset (async, active-low)
//   start, uap_dci[7:0], payload_len[LEN_W-1:0] : frame setup, sampled on start
//   data_in, valid_in                          : serial receive bit stream
//   busy, done, crc_ok, crc_err, crc_reg       : registered status / LFSR contents
module crc16_check_bluetooth #(
  parameter int unsigned CRC_LEGNTH = 16,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            uap_dci,
  input  logic [LEN_W-1:0]      payload_len,
  input  logic                  data_in,
  input  logic                  valid_in,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_ok,
  output logic                  crc_err,
  output logic [CRC_LEGNTH-1:0] crc_reg
);

  localparam int unsigned SEED_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC_CMP = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CRC_LEGNTH-1:0]   crc_d;
  logic [CRC_LEGNTH-1:0]   crc_shift;
  logic [CRC_LEGNTH-1:0]   crc_seed;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    ok_d, err_d, busy_d, done_d;
  logic                    fb;

  // One LFSR step for the current input bit.
  always_comb begin
    fb        = crc_reg[15] ^ data_in;
    crc_shift = {crc_reg[14:12], crc_reg[11] ^ fb, crc_reg[10:5],
                 crc_reg[4] ^ fb, crc_reg[3:0], fb};
  end

  // UAP/DCI is loaded bit-reversed into the low byte; high byte clears.
  always_comb begin
    crc_seed = '0;
    for (int i = 0; i < int'(SEED_W); i++) begin
      crc_seed[SEED_W-1-i] = uap_dci[i];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_reg;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ok_d    = crc_ok;
    err_d   = crc_err;

    if (start) begin
      // start wins in every state, including DONE, and masks valid_in.
      crc_d   = crc_seed;
      len_d   = payload_len;
      cnt_d   = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      state_d = (payload_len == '0) ? CRC_CMP : PAYLOAD;
    end else begin
      case (state_q)
        IDLE: ;
        PAYLOAD: begin
          if (valid_in) begin
            crc_d = crc_shift;
            // len_q is non-zero here, so len_q-1 never underflows.
            if (cnt_q == len_q - LEN_W'(1)) begin
              cnt_d   = '0;
              state_d = CRC_CMP;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
        end
        CRC_CMP: begin
          if (valid_in) begin
            crc_d = crc_shift;
            if (cnt_q == LEN_W'(CRC_LEGNTH - 1)) begin
              cnt_d   = '0;
              ok_d    = (crc_shift == '0);
              err_d   = (crc_shift != '0);
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == PAYLOAD) || (state_d == CRC_CMP);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      crc_reg <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_reg <= crc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      crc_ok  <= ok_d;
      crc_err <= err_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_crc16_check_bluetooth.sv
// Testbench for crc16_check_bluetooth: directed frames with a scoreboard of
// expected {crc_ok, crc_err} results popped on each done pulse.
module tb_crc16_check_bluetooth;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       uap_dci;
  logic [LEN_W-1:0] payload_len;
  logic             data_in;
  logic             valid_in;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic [15:0]      crc_reg;

  crc16_check_bluetooth #(.CRC_LEGNTH(16), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .uap_dci     (uap_dci),
    .payload_len (payload_len),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .busy        (busy),
    .done        (done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .crc_reg     (crc_reg)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [1:0]  exp_q[$];
  logic [15:0] m_crc;

  // Reference LFSR step in mask form.
  function automatic logic [15:0] lfsr(input logic [15:0] c, input logic d);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (c[15] ^ d) n = n ^ 16'h1021;
    return n;
  endfunction

  function automatic logic [15:0] seed(input logic [7:0] u);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s[7-i] = u[i];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      int         pending;
      logic [1:0] e;
      pending = exp_q.size();
      chk("sb_pending", 32'(pending != 0), 32'd1);
      if (pending != 0) begin
        e = exp_q.pop_front();
        chk("sb_result", 32'({crc_ok, crc_err}), 32'(e));
      end
    end
  end

  task automatic start_frame(input logic [7:0] u, input logic [LEN_W-1:0] len);
    start       = 1'b1;
    uap_dci     = u;
    payload_len = len;
    valid_in    = 1'b1;   // must be ignored in the start cycle
    data_in     = 1'b1;
    cyc();
    start    = 1'b0;
    valid_in = 1'b0;
    m_crc    = seed(u);
    chk("start_crc", 32'(crc_reg), 32'(m_crc));
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_clr", 32'({crc_ok, crc_err}), 32'd0);
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    int gaps;
    gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    for (int g = 0; g < gaps; g++) begin
      valid_in = 1'b0;
      data_in  = ~b;
      cyc();
      chk("gap_hold", 32'(crc_reg), 32'(m_crc));
    end
    valid_in = 1'b1;
    data_in  = b;
    cyc();
    valid_in = 1'b0;
    m_crc    = lfsr(m_crc, b);
    chk("bit_crc", 32'(crc_reg), 32'(m_crc));
  endtask

  // Full frame: transmitter CRC computed over the clean payload; optional
  // single-bit corruption in the payload or CRC field (index, -1 for none).
  task automatic run_frame(input logic [7:0] u, input logic [63:0] pay, input int len,
                           input int flip_pay, input int flip_crc, input int maxgap,
                           input bit linger);
    logic [15:0] tx;
    logic        good;
    tx = seed(u);
    for (int i = 0; i < len; i++) tx = lfsr(tx, pay[i]);
    good = (flip_pay < 0) && (flip_crc < 0);
    start_frame(u, LEN_W'(len));
    exp_q.push_back({good, ~good});
    for (int i = 0; i < len; i++) send_bit(pay[i] ^ (i == flip_pay), maxgap);
    for (int j = 0; j < 16; j++) begin
      chk("busy_run", 32'(busy), 32'd1);
      send_bit(tx[15-j] ^ (j == flip_crc), maxgap);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("result", 32'({crc_ok, crc_err}), 32'({good, ~good}));
    if (linger) begin
      valid_in = 1'b1;  // ignored in DONE and IDLE
      data_in  = 1'b1;
      cyc();
      chk("done_once", 32'(done), 32'd0);
      chk("held", 32'({crc_ok, crc_err}), 32'({good, ~good}));
      chk("idle_crc", 32'(crc_reg), 32'(m_crc));
      valid_in = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] pay;
    logic [15:0] c47;

    reset       = 1'b0;
    start       = 1'b0;
    uap_dci     = '0;
    payload_len = '0;
    data_in     = 1'b0;
    valid_in    = 1'b0;
    #1;
    chk("rst_crc", 32'(crc_reg), 32'd0);
    chk("rst_flags", 32'({busy, done, crc_ok, crc_err}), 32'd0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    chk("idle_flags", 32'({busy, done, crc_ok, crc_err}), 32'd0);

    // All-zero frame, then the same with the 3rd CRC bit flipped.
    run_frame(8'h00, 64'h0, 8, -1, -1, 0, 1'b1);
    run_frame(8'h00, 64'h0, 8, -1, 2, 0, 1'b1);

    // Empty payload: seed 0x47 -> 0x00E2, then that CRC MSB first.
    start_frame(8'h47, '0);
    chk("seed_0x47", 32'(crc_reg), 32'h0000_00E2);
    exp_q.push_back(2'b10);
    c47 = 16'h00E2;
    for (int j = 0; j < 16; j++) send_bit(c47[15-j], 0);
    chk("p0_done", 32'(done), 32'd1);
    chk("p0_ok", 32'({crc_ok, crc_err}), 32'b10);
    cyc();

    // Random 40-bit payload with gaps, then every single-bit corruption;
    // alternate frames restart straight from DONE.
    pay = {$urandom, $urandom};
    run_frame(8'hA5, pay, 40, -1, -1, 3, 1'b1);
    for (int k = 0; k < 40; k++) run_frame(8'hA5, pay, 40, k, -1, 3, 1'(k % 2));

    // Restart after 5 payload bits; the abandoned bits must not matter.
    start_frame(8'hA5, 16'd40);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1);
    run_frame(8'hA5, pay, 40, -1, -1, 1, 1'b1);

    // Length boundaries: one bit and 64 bits.
    run_frame(8'h3C, 64'h1, 1, -1, -1, 0, 1'b1);
    pay = {$urandom, $urandom};
    run_frame(8'h5A, pay, 64, -1, -1, 2, 1'b1);
    run_frame(8'h5A, pay, 64, -1, 15, 0, 1'b1);

    // Reset in the middle of the CRC field.
    start_frame(8'h00, 16'd8);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
    for (int j = 0; j < 5; j++) send_bit(1'b0, 0);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_crc", 32'(crc_reg), 32'd0);
    chk("arst_flags", 32'({busy, done, crc_ok, crc_err}), 32'd0);
    cyc();
    cyc();
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_crc", 32'(crc_reg), 32'd0);
      chk("post_rst_flags", 32'({busy, done, crc_ok, crc_err}), 32'd0);
    end
    valid_in = 1'b0;
    cyc();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc16_check_bluetooth.md
CRC16_CHECK_BLUETOOTH -- requirements
Module: crc16_check_bluetooth

Interface
REQ-001 SHALL have parameter CRC_LEGNTH, default 16, CRC register width; only 16 is supported.
REQ-002 SHALL have parameter LEN_W, default 16, width of the payload bit-length field.
REQ-003 SHALL have clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have reset, input, 1: reset is asynchronous and active-low.
REQ-005 SHALL have start, input, 1: one-cycle pulse that initialises the LFSR and latches the payload length.
REQ-006 SHALL have uap_dci, input, 8: UAP/DCI seed, sampled on start.
REQ-007 SHALL have payload_len, input, LEN_W: payload length in bits, sampled on start.
REQ-008 SHALL have data_in, input, 1: received serial bit, qualified by valid_in.
REQ-009 SHALL have valid_in, input, 1: data_in is valid this cycle; may drop for any number of cycles.
REQ-010 SHALL have busy, output, 1: high while in PAYLOAD or CRC_CMP.
REQ-011 SHALL have done, output, 1: one-cycle pulse when the check completes.
REQ-012 SHALL have crc_ok, output, 1: check passed, held until next start or reset.
REQ-013 SHALL have crc_err, output, 1: check failed, held until next start or reset.
REQ-014 SHALL have crc_reg, output, CRC_LEGNTH: current LFSR contents.

Function
REQ-015 SHALL use polynomial x^16+x^12+x^5+1: fb = crc_reg[15]^data_in; next = {crc[14:12], crc[11]^fb, crc[10:5], crc[4]^fb, crc[3:0], fb}.
REQ-016 SHALL implement an FSM with states IDLE, PAYLOAD, CRC_CMP and DONE.
REQ-017 SHALL, on start in any state, load crc_reg[7-i] = uap_dci[i] for i = 0..7 and crc_reg[15:8] = 0.
REQ-018 SHALL, on start, latch payload_len, clear the bit counter, clear crc_ok and crc_err, and enter PAYLOAD, or CRC_CMP if payload_len = 0.
REQ-019 SHALL ignore valid_in in the start cycle; start has priority over valid_in.
REQ-020 SHALL, in PAYLOAD or CRC_CMP, apply one LFSR update and increment the counter in every cycle with valid_in = 1; with valid_in = 0, LFSR and counter hold.
REQ-021 SHALL move PAYLOAD -> CRC_CMP in the cycle that the payload_len-th payload bit is accepted, and reset the counter to 0 in that cycle.
REQ-022 SHALL treat received CRC bits as ordered transmitter crc_reg[15] first down to crc_reg[0], and shift them through the same LFSR.
REQ-023 SHALL, when the 16th CRC bit is accepted, evaluate the next LFSR value: zero sets crc_ok, non-zero sets crc_err, and the FSM enters DONE.
REQ-024 SHALL assert done for exactly the one cycle spent in DONE, which is the cycle after the 16th CRC bit, and then return to IDLE.
REQ-025 SHALL ensure crc_ok and crc_err are never high together.
REQ-026 SHALL ignore valid_in while in IDLE or DONE; crc_reg holds its value.
REQ-027 SHALL give the counter LEN_W bits and let it never wrap within a frame; payload_len = 2^LEN_W-1 is supported.
REQ-028 SHALL have start in DONE take priority: crc_ok and crc_err clear and the new frame begins, while done still pulses that cycle.

Reset
REQ-029 SHALL, on reset low, asynchronously set state = IDLE, crc_reg = 16'h0000, counter = 0, and busy, done, crc_ok and crc_err = 0.
REQ-030 SHALL, on reset mid-frame, abandon the frame with no done pulse; a new start is required after reset release.

Verification
REQ-031 SHALL cover: uap_dci=0x00, payload_len=8, 8 zero bits, then 16 zero CRC bits -> done 1 cycle after the last bit, crc_ok=1, crc_err=0.
REQ-032 SHALL cover: as REQ-031 but the 3rd CRC bit flipped to 1 -> crc_ok=0, crc_err=1, done pulses once.
REQ-033 SHALL cover: uap_dci=0x47, payload_len=0 -> crc_reg=0x00E2 after start, busy=1, then CRC bits 0x00E2 sent MSB first -> crc_ok=1.
REQ-034 SHALL cover: a random 40-bit payload from the team's TX crc16_bluetooth with uap_dci=0xA5 and valid_in gaps of 0-3 cycles -> crc_ok=1; each single-bit payload corruption -> crc_err=1.
REQ-035 SHALL cover: start reasserted after 5 payload bits -> counter restarts, earlier bits have no effect, crc_ok=1 for the clean second frame.
REQ-036 SHALL cover: reset low during CRC_CMP -> all outputs 0 immediately, no done, crc_reg=0x0000.
